// File: rtl/alu_pkg.sv
// alu_pkg: shared function codes, state encoding and default widths for alu_pipe
package alu_pkg;
  localparam int ALU_DATA_W = 16;
  localparam int ALU_FUNC_W = 4;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_IN1   = 4'd0;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_ADD   = 4'd1;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_MUL   = 4'd2;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_AND   = 4'd3;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_1H_0L = 4'd4;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_1L_0L = 4'd5;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_1H_0H = 4'd6;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_0H_1L = 4'd7;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_LT    = 4'd8;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_EQ    = 4'd9;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_NE    = 4'd10;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_ST    = 4'd11;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_SUB   = 4'd12;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_SLT   = 4'd13;
  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one bit per cycle, low W bits of the product
module alu_mul_iter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] prod
);
  localparam int CW = $clog2(W);
  logic [CW-1:0] r_cnt;
  logic [W-1:0] r_acc, r_mcand, r_mplier;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        r_cnt <= CW'(W - 1);
        r_acc <= '0;
        r_mcand <= a;
        r_mplier <= b;
      end else if (busy) begin
        r_acc <= r_acc + (r_mplier[0] ? r_mcand : '0);
        r_mcand <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
  assign prod = r_acc;
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked tagged-word ALU with iterative MUL and store port; ALU_PIPE_SUB_EN adds SUB/SLT
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int FUNC_W = ALU_FUNC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_data0,
  input  logic [2*DATA_W-1:0] in_data1,
  input  logic [FUNC_W-1:0]   func_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_err,
  output logic                st_valid,
  output logic [DATA_W-1:0]   st_addr,
  output logic [DATA_W-1:0]   st_data
);
  localparam int W = DATA_W;
  state_t r_state;
  logic [W-1:0] w_t0, w_v0, w_t1, w_v1, w_prod, r_mul_tag;
  logic [2*W-1:0] w_res;
  logic w_err, w_issue, w_mul_issue, w_mul_busy, w_mul_done;
  assign {w_t0, w_v0} = in_data0;
  assign {w_t1, w_v1} = in_data1;
  assign in_ready = !rst && r_state == IDLE && !w_mul_busy && (!out_valid || out_ready);
  assign w_issue = in_valid && in_ready;
  assign w_mul_issue = w_issue && func_sel == ALU_FUNC_MUL;
  always_comb begin
    w_res = {w_t0, {W{1'b0}}};
    w_err = 1'b0;
    case (func_sel)
      ALU_FUNC_IN1:   w_res = in_data1;
      ALU_FUNC_ADD:   w_res = {w_t0, w_v0 + w_v1};
      ALU_FUNC_MUL:   w_res = {w_t0, {W{1'b0}}};
      ALU_FUNC_AND:   w_res = {w_t0, w_v0 & w_v1};
      ALU_FUNC_1H_0L: w_res = {w_t1, w_v0};
      ALU_FUNC_1L_0L: w_res = {w_v1, w_v0};
      ALU_FUNC_1H_0H: w_res = {w_t1, w_t0};
      ALU_FUNC_0H_1L: w_res = {w_t0, w_v1};
      ALU_FUNC_LT:    w_res = {w_t0, {(W-1){1'b0}}, w_v0 < w_v1};
      ALU_FUNC_EQ:    w_res = {w_t0, {(W-1){1'b0}}, w_v0 == w_v1};
      ALU_FUNC_NE:    w_res = {w_t0, {(W-1){1'b0}}, w_v0 != w_v1};
      ALU_FUNC_ST:    w_res = in_data0;
`ifdef ALU_PIPE_SUB_EN
      ALU_FUNC_SUB:   w_res = {w_t0, w_v0 - w_v1};
      ALU_FUNC_SLT:   w_res = {w_t0, {(W-1){1'b0}}, $signed(w_v0) < $signed(w_v1)};
`endif
      default:        w_err = 1'b1;
    endcase
  end
  alu_mul_iter #(.W(W)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(w_mul_issue),
    .a(w_v0),
    .b(w_v1),
    .busy(w_mul_busy),
    .done(w_mul_done),
    .prod(w_prod)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mul_tag <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_err <= 1'b0;
      st_valid <= 1'b0;
      st_addr <= '0;
      st_data <= '0;
    end else begin
      st_valid <= w_issue && func_sel == ALU_FUNC_ST;
      if (w_issue && func_sel == ALU_FUNC_ST) begin
        st_addr <= w_v0;
        st_data <= w_v1;
      end
      if (r_state == MUL_BUSY) begin
        if (w_mul_done) begin
          r_state <= IDLE;
          out_valid <= 1'b1;
          out_data <= {r_mul_tag, w_prod};
          out_err <= 1'b0;
        end
      end else if (w_mul_issue) begin
        r_state <= MUL_BUSY;
        r_mul_tag <= w_t0;
        out_valid <= 1'b0;
      end else if (w_issue) begin
        out_valid <= 1'b1;
        out_data <= w_res;
        out_err <= w_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
